// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  localparam int DBITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } fsmState;

  // Offset is taken modulo 2^DBITS, so an address below the base must be rejected explicitly.
  function automatic logic isFault(
    input logic [DBITS-1:0] addr,
    input logic [DBITS-1:0] base,
    input logic [DBITS-1:0] words
  );
    logic [DBITS-1:0] offset;
    offset = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((offset >> 2) >= words);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channels plus the write-only load port.
interface imem_if;
  import imem_pkg::*;

  logic             reqValid;
  logic [DBITS-1:0] reqAddr;
  logic             reqReady;
  logic             respValid;
  logic [DBITS-1:0] respData;
  logic             respFault;
  logic             respReady;
  logic             loadEn;
  logic [DBITS-1:0] loadAddr;
  logic [DBITS-1:0] loadData;

  modport master (
    output reqValid, reqAddr, respReady, loadEn, loadAddr, loadData,
    input  reqReady, respValid, respData, respFault
  );

  modport slave (
    input  reqValid, reqAddr, respReady, loadEn, loadAddr, loadData,
    output reqReady, respValid, respData, respFault
  );
endinterface

// File: rtl/imem_responder_array.sv
// Single-write, single-read synchronous word RAM with a registered read port.
module imem_array
  import imem_pkg::*;
#(
  parameter int WORDS = 2048,
  parameter int ABITS = 11
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [ABITS-1:0] wrAddr,
  input  logic [DBITS-1:0] wrData,
  input  logic             rdEn,
  input  logic [ABITS-1:0] rdAddr,
  output logic [DBITS-1:0] rdData
);
  logic [DBITS-1:0] mem [WORDS];

  // Read returns the pre-write contents on an address collision.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch with fault flagging and a load port.
// Optional one-entry next-word prefetch buffer enabled by defining IMEM_PREFETCH_EN.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [DBITS-1:0] IMEM_BASE    = '0,
  parameter int               IMEM_WORDS   = 2048,
  parameter int               READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  imem_if.slave bus
);
  localparam int                        IMEM_ADDR_BITS = $clog2(IMEM_WORDS);
  localparam logic [DBITS-1:0]          WORDS_W        = DBITS'(IMEM_WORDS);
  localparam logic [2:0]                LAT_LOAD       = 3'(READ_LATENCY - 1);
  localparam logic [IMEM_ADDR_BITS-1:0] LAST_IDX       = IMEM_ADDR_BITS'(IMEM_WORDS - 1);

  fsmState                   stateReg, stateNext;
  logic [2:0]                cntReg, cntNext;
  logic                      faultReg, faultNext;
  logic                      reqFault, loadOk, rdEn;
  logic [IMEM_ADDR_BITS-1:0] reqIdx, loadIdx, rdAddr;
  logic [DBITS-1:0]          rdData;
  logic                      reqReady, respValid, respFault;
  logic [DBITS-1:0]          respData;
`ifdef IMEM_PREFETCH_EN
  logic                      pfValidReg, pfValidNext;
  logic [IMEM_ADDR_BITS-1:0] pfIndexReg, pfIndexNext;
  logic [IMEM_ADDR_BITS-1:0] idxReg, idxNext;
`endif

  assign reqFault = isFault(bus.reqAddr, IMEM_BASE, WORDS_W);
  assign loadOk   = bus.loadEn && !isFault(bus.loadAddr, IMEM_BASE, WORDS_W);
  assign reqIdx   = IMEM_ADDR_BITS'((bus.reqAddr - IMEM_BASE) >> 2);
  assign loadIdx  = IMEM_ADDR_BITS'((bus.loadAddr - IMEM_BASE) >> 2);

  imem_array #(
    .WORDS (IMEM_WORDS),
    .ABITS (IMEM_ADDR_BITS)
  ) uArray (
    .clk    (clk),
    .wrEn   (loadOk),
    .wrAddr (loadIdx),
    .wrData (bus.loadData),
    .rdEn   (rdEn),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      faultReg   <= 1'b0;
`ifdef IMEM_PREFETCH_EN
      pfValidReg <= 1'b0;
      pfIndexReg <= '0;
      idxReg     <= '0;
`endif
    end else begin
      stateReg   <= stateNext;
      cntReg     <= cntNext;
      faultReg   <= faultNext;
`ifdef IMEM_PREFETCH_EN
      pfValidReg <= pfValidNext;
      pfIndexReg <= pfIndexNext;
      idxReg     <= idxNext;
`endif
    end
  end

  always_comb begin
    stateNext   = stateReg;
    cntNext     = cntReg;
    faultNext   = faultReg;
    rdEn        = 1'b0;
    rdAddr      = reqIdx;
    reqReady    = 1'b0;
    respValid   = 1'b0;
    respFault   = 1'b0;
    respData    = '0;
`ifdef IMEM_PREFETCH_EN
    pfValidNext = pfValidReg;
    pfIndexNext = pfIndexReg;
    idxNext     = idxReg;
`endif
    case (stateReg)
      IDLE: begin
        // A load in the same cycle takes the array and blocks acceptance.
        reqReady = !bus.loadEn && !reset;
        if (bus.reqValid && reqReady) begin
          faultNext = reqFault;
          rdEn      = !reqFault;
`ifdef IMEM_PREFETCH_EN
          idxNext   = reqIdx;
          if (pfValidReg && !reqFault && (reqIdx == pfIndexReg)) begin
            stateNext = RESP;
          end else begin
            pfValidNext = 1'b0;
            if (READ_LATENCY == 1) begin
              stateNext = RESP;
            end else begin
              stateNext = BUSY;
              cntNext   = LAT_LOAD;
            end
          end
`else
          if (READ_LATENCY == 1) begin
            stateNext = RESP;
          end else begin
            stateNext = BUSY;
            cntNext   = LAT_LOAD;
          end
`endif
        end
      end
      BUSY: begin
        cntNext = cntReg - 3'd1;
        if (cntReg == 3'd1) stateNext = RESP;
      end
      RESP: begin
        respValid = 1'b1;
        respFault = faultReg;
        respData  = faultReg ? '0 : rdData;
        if (bus.respReady) begin
          stateNext = IDLE;
`ifdef IMEM_PREFETCH_EN
          if (!faultReg && (idxReg != LAST_IDX)) begin
            rdEn        = 1'b1;
            rdAddr      = idxReg + 1'b1;
            pfValidNext = 1'b1;
            pfIndexNext = idxReg + 1'b1;
          end
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
`ifdef IMEM_PREFETCH_EN
    if (loadOk && (loadIdx == pfIndexNext)) pfValidNext = 1'b0;
`endif
  end

  assign bus.reqReady  = reqReady;
  assign bus.respValid = respValid;
  assign bus.respFault = respFault;
  assign bus.respData  = respData;
endmodule
